// File: rtl/seq_mult_unit.sv
// seq_mult_unit: iterative shift-add multiplier, signed or unsigned, one
// partial product per clock, with a start/done handshake.
//
// Optional feature macro: MULT_ACCUM_EN (product accumulator).
//
// Ports:
//   clk        rising-edge clock
//   reset      async reset, active-low
//   start      launches an operation when sampled high in IDLE or DONE
//   is_signed  1 = two's-complement operands (latched with start)
//   op_a       multiplicand (latched with start)
//   op_b       multiplier (latched with start)
//   acc_en     add product into accumulator on completion (MULT_ACCUM_EN)
//   acc_clr    synchronous accumulator clear (MULT_ACCUM_EN)
//   busy       high while the multiply is running
//   done       high once a result is ready; held until next start
//   prod       2*WIDTH-bit product, valid while done=1
//   acc_out    accumulator value (0 when MULT_ACCUM_EN is undefined)
module seq_mult_unit #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_GUARD = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            is_signed,
    input  logic [WIDTH-1:0]                op_a,
    input  logic [WIDTH-1:0]                op_b,
    input  logic                            acc_en,
    input  logic                            acc_clr,
    output logic                            busy,
    output logic                            done,
    output logic [2*WIDTH-1:0]              prod,
    output logic [2*WIDTH+ACC_GUARD-1:0]    acc_out
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = PW + ACC_GUARD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH:0]     mcand_q, mcand_d;
    logic               sgn_q, sgn_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [PW-1:0]      prod_q, prod_d;

    logic               last_c;
    logic [WIDTH:0]     add_c;
    logic [WIDTH:0]     hi_nxt_c;
    logic [WIDTH-1:0]   lo_nxt_c;
    logic               finish_c;

    // One shift-add step; the final signed step subtracts because the
    // multiplier MSB carries negative weight.
    always_comb begin
        last_c = (cnt_q == CW'(WIDTH - 1));
        add_c  = hi_q;
        if (lo_q[0]) begin
            if (last_c && sgn_q) begin
                add_c = hi_q - mcand_q;
            end else begin
                add_c = hi_q + mcand_q;
            end
        end
        // Unsigned fill is 0 so a carry in add_c[WIDTH] shifts down intact.
        {hi_nxt_c, lo_nxt_c} = {(sgn_q & add_c[WIDTH]), add_c, lo_q[WIDTH-1:1]};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        sgn_d    = sgn_q;
        busy_d   = busy_q;
        done_d   = done_q;
        prod_d   = prod_q;
        finish_c = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = op_b;
                    mcand_d = is_signed ? {op_a[WIDTH-1], op_a} : {1'b0, op_a};
                    sgn_d   = is_signed;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                hi_d  = hi_nxt_c;
                lo_d  = lo_nxt_c;
                cnt_d = cnt_q + CW'(1);
                if (last_c) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    prod_d   = {hi_nxt_c[WIDTH-1:0], lo_nxt_c};
                    finish_c = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            sgn_q   <= sgn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign prod = prod_q;

`ifdef MULT_ACCUM_EN
    logic [AW-1:0] acc_q, acc_d;

    // Clear wins over an accumulate landing on the same edge.
    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (finish_c && acc_en) begin
            if (sgn_q) begin
                acc_d = acc_q + AW'($signed(prod_d));
            end else begin
                acc_d = acc_q + AW'(prod_d);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_out = acc_q;
`else
    wire unused_acc = &{1'b0, acc_en, acc_clr, finish_c};

    assign acc_out = AW'(0);
`endif

endmodule

// File: tb/tb_seq_mult_unit.sv
// Bench for seq_mult_unit (WIDTH=8): arithmetic reference model checked every
// cycle, plus directed operations with literal expected products.
module tb_seq_mult_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        acc_en;
    logic        acc_clr;
    logic        busy;
    logic        done;
    logic [15:0] prod;
    logic [19:0] acc_out;

    int total = 0;
    int bad   = 0;

    seq_mult_unit #(.WIDTH(8), .ACC_GUARD(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .busy      (busy),
        .done      (done),
        .prod      (prod),
        .acc_out   (acc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b, input logic s);
        int ia, ib;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        return 16'(ia * ib);
    endfunction

    // Reference model: countdown of cycles to completion and an arithmetic product.
    logic        m_busy, m_done, m_sgn;
    logic [15:0] m_prod, m_res;
    logic [19:0] m_acc;
    int          m_left;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_prod <= '0;
            m_res  <= '0;
            m_sgn  <= 1'b0;
            m_acc  <= '0;
            m_left <= 0;
        end else begin
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_prod <= m_res;
                end
            end else if (start) begin
                m_busy <= 1'b1;
                m_done <= 1'b0;
                m_left <= 8;
                m_res  <= ref_prod(op_a, op_b, is_signed);
                m_sgn  <= is_signed;
            end
`ifdef MULT_ACCUM_EN
            if (acc_clr) begin
                m_acc <= '0;
            end else if (m_busy && m_left == 1 && acc_en) begin
                m_acc <= m_acc + (m_sgn ? 20'(int'($signed(m_res))) : 20'(m_res));
            end
`endif
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        if (m_done) chk("prod", 32'(prod), 32'(m_prod));
        chk("acc_out", 32'(acc_out), 32'(m_acc));
    end

    // Launch one op, expect done cleared after the launch edge and set 8 edges later.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          output logic [15:0] p);
        int n;
        @(posedge clk); #1;
        start = 1'b1; op_a = a; op_b = b; is_signed = s;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_clr", 32'(done), 32'(0));
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 40);
        chk("latency", 32'(n), 32'(8));
        p = prod;
    endtask

    logic [7:0]  vals [14];
    logic [15:0] p;

    initial begin
        vals = '{8'h80, 8'h81, 8'hC0, 8'hFD, 8'hFF, 8'h00, 8'h01,
                 8'h02, 8'h05, 8'h3F, 8'h40, 8'h7F, 8'h64, 8'h9C};
        reset = 1'b0; start = 1'b0; is_signed = 1'b0;
        op_a = '0; op_b = '0; acc_en = 1'b0; acc_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_prod", 32'(prod), 32'(0));
        chk("rst_acc", 32'(acc_out), 32'(0));
        reset = 1'b1;

        run_op(8'hC0, 8'hC0, 1'b1, p); chk("m64xm64", 32'(p), 32'h1000);
        run_op(8'h7F, 8'h80, 1'b1, p); chk("127xm128", 32'(p), 32'hC080);
        run_op(8'h80, 8'h80, 1'b1, p); chk("m128xm128", 32'(p), 32'h4000);
        run_op(8'hFF, 8'hFF, 1'b0, p); chk("u255x255", 32'(p), 32'hFE01);
        run_op(8'hC8, 8'h03, 1'b0, p); chk("u200x3", 32'(p), 32'h0258);
        run_op(8'hC8, 8'h03, 1'b1, p); chk("s56x3", 32'(p), 32'hFF58);
        run_op(8'h00, 8'h9C, 1'b1, p); chk("zero_a", 32'(p), 32'h0000);
        run_op(8'h9C, 8'h00, 1'b0, p); chk("zero_b", 32'(p), 32'h0000);

        foreach (vals[i]) begin
            foreach (vals[j]) begin
                run_op(vals[i], vals[j], 1'b1, p);
            end
        end

        // Second start three cycles into RUN must be ignored.
        begin
            int n;
            @(posedge clk); #1;
            start = 1'b1; op_a = 8'd13; op_b = 8'd11; is_signed = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n = 0;
            repeat (2) begin @(posedge clk); #1; n++; end
            start = 1'b1; op_a = 8'd99; op_b = 8'd99;
            @(posedge clk); #1;
            start = 1'b0; n++;
            while (!done && n < 40) begin @(posedge clk); #1; n++; end
            chk("restart_lat", 32'(n), 32'(8));
            chk("restart_prod", 32'(prod), 32'd143);
        end

        // Result held with no start.
        repeat (20) @(posedge clk);
        #1;
        chk("hold_done", 32'(done), 32'(1));
        chk("hold_prod", 32'(prod), 32'd143);
        run_op(8'd2, 8'd2, 1'b0, p); chk("after_hold", 32'(p), 32'd4);

        // Asynchronous reset four cycles into RUN.
        @(posedge clk); #1;
        start = 1'b1; op_a = 8'd7; op_b = 8'd9; is_signed = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_done", 32'(done), 32'(0));
        chk("arst_prod", 32'(prod), 32'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        run_op(8'd7, 8'd9, 1'b0, p); chk("post_rst", 32'(p), 32'd63);

`ifdef MULT_ACCUM_EN
        @(posedge clk); #1;
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        chk("acc_clr", 32'(acc_out), 32'd0);
        acc_en = 1'b1;
        run_op(8'd10, 8'd10, 1'b1, p);
        run_op(8'hFD, 8'd7, 1'b1, p);
        chk("acc_79", 32'(acc_out), 32'd79);
        acc_clr = 1'b1;
        run_op(8'd5, 8'd5, 1'b1, p);
        chk("acc_clr_wins", 32'(acc_out), 32'd0);
        acc_clr = 1'b0;
        acc_en = 1'b0;
`else
        acc_en = 1'b1;
        run_op(8'd10, 8'd10, 1'b1, p);
        chk("acc_tied", 32'(acc_out), 32'd0);
        acc_en = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
